// File: rtl/pll_ctrl_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pll_ctrl_pkg                                                           |
// | Shared types, widths and default constants for the PLL controller.     |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
package pll_ctrl_pkg;

    localparam int c_TIMER_W    = 13;
    localparam int c_GOOD_W     = 5;
    localparam int c_RETRY_W    = 2;
    localparam int c_GAP_CYCLES = 2;

    localparam int c_DEF_RESET_HOLD  = 4;
    localparam int c_DEF_START_HOLD  = 2;
    localparam int c_DEF_CAL_TIMEOUT = 8191;
    localparam int c_DEF_LOCK_GOOD   = 16;
    localparam int c_DEF_LOSS_COUNT  = 4;
    localparam int c_DEF_MAX_RETRY   = 3;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_RESET      = 3'd1,
        ST_GAP        = 3'd2,
        ST_START      = 3'd3,
        ST_WAIT_CAL   = 3'd4,
        ST_LOCK_CHECK = 3'd5,
        ST_LOCKED     = 3'd6,
        ST_FAIL       = 3'd7
    } state_t;

    typedef struct packed {
        logic pll_reset;
        logic start_cal;
        logic busy;
        logic locked;
        logic fail;
    } ctrl_out_t;

    // Per-state values of the PLL-facing and status outputs.
    function automatic ctrl_out_t decode_state(input state_t s);
        ctrl_out_t o;
        o.pll_reset = (s == ST_IDLE) || (s == ST_RESET) || (s == ST_FAIL);
        o.start_cal = (s == ST_START);
        o.busy      = (s == ST_RESET) || (s == ST_GAP) || (s == ST_START) ||
                      (s == ST_WAIT_CAL) || (s == ST_LOCK_CHECK);
        o.locked    = (s == ST_LOCKED);
        o.fail      = (s == ST_FAIL);
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_ctrl_sync2.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pll_ctrl_sync2                                                         |
// | Two-flop synchronizer with asynchronous active-high reset.             |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module pll_ctrl_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pll_calibration_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | pll_calibration_controller                                             |
// | Sequences the readout PLL through reset, calibration and lock          |
// | qualification with retry; PLL_CTRL_AUTO_RELOCK_EN enables relock.      |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module pll_calibration_controller
    import pll_ctrl_pkg::*;
#(
    parameter int RESET_HOLD  = c_DEF_RESET_HOLD,
    parameter int START_HOLD  = c_DEF_START_HOLD,
    parameter int CAL_TIMEOUT = c_DEF_CAL_TIMEOUT,
    parameter int LOCK_GOOD   = c_DEF_LOCK_GOOD,
    parameter int LOSS_COUNT  = c_DEF_LOSS_COUNT,
    parameter int MAX_RETRY   = c_DEF_MAX_RETRY
) (
    input  logic                 clk40,
    input  logic                 asynReset,
    input  logic                 enable,
    input  logic                 pllCalibrationDone,
    input  logic                 instantLock,
    output logic                 pllReset,
    output logic                 startCalibration,
    output logic                 busy,
    output logic                 locked,
    output logic                 fail,
    output logic                 lossOfLock,
    output logic [c_RETRY_W-1:0] retryCount
);

    localparam logic [c_TIMER_W-1:0] c_RESET_LAST = c_TIMER_W'(RESET_HOLD - 1);
    localparam logic [c_TIMER_W-1:0] c_GAP_LAST   = c_TIMER_W'(c_GAP_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_START_LAST = c_TIMER_W'(START_HOLD - 1);
    localparam logic [c_TIMER_W-1:0] c_TIMEOUT    = c_TIMER_W'(CAL_TIMEOUT);
    localparam logic [c_GOOD_W-1:0]  c_GOOD_LAST  = c_GOOD_W'(LOCK_GOOD - 1);
    localparam logic [c_GOOD_W-1:0]  c_LOSS_LAST  = c_GOOD_W'(LOSS_COUNT - 1);
    localparam logic [c_RETRY_W-1:0] c_RETRY_MAX  = c_RETRY_W'(MAX_RETRY);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [c_TIMER_W-1:0] r_timer;
    logic [c_GOOD_W-1:0]  r_good;
    logic [c_GOOD_W-1:0]  w_good_nxt;
    logic [c_GOOD_W-1:0]  r_loss;
    logic [c_GOOD_W-1:0]  w_loss_nxt;
    logic [c_RETRY_W-1:0] r_retry;
    logic [c_RETRY_W-1:0] w_retry_nxt;
    logic                 r_lol;
    logic                 w_lol_nxt;
    logic                 w_do_retry;
    logic                 w_loss_event;
    logic                 w_sync_done;
    logic                 w_sync_lock;
    ctrl_out_t            w_dec;

    pll_ctrl_sync2 u_sync_done (
        .clk (clk40),
        .rst (asynReset),
        .d   (pllCalibrationDone),
        .q   (w_sync_done)
    );

    pll_ctrl_sync2 u_sync_lock (
        .clk (clk40),
        .rst (asynReset),
        .d   (instantLock),
        .q   (w_sync_lock)
    );

    assign w_dec = decode_state(r_state);

    always_comb begin
        w_state_nxt  = r_state;
        w_good_nxt   = r_good;
        w_loss_nxt   = r_loss;
        w_retry_nxt  = r_retry;
        w_lol_nxt    = r_lol;
        w_do_retry   = 1'b0;
        w_loss_event = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_RESET;
                w_retry_nxt = '0;
                w_lol_nxt   = 1'b0;
            end
            ST_RESET: begin
                if (r_timer == c_RESET_LAST) w_state_nxt = ST_GAP;
            end
            ST_GAP: begin
                if (r_timer == c_GAP_LAST) w_state_nxt = ST_START;
            end
            ST_START: begin
                if (r_timer == c_START_LAST) w_state_nxt = ST_WAIT_CAL;
            end
            ST_WAIT_CAL: begin
                if (w_sync_done)                w_state_nxt = ST_LOCK_CHECK;
                else if (r_timer == c_TIMEOUT)  w_do_retry  = 1'b1;
            end
            ST_LOCK_CHECK: begin
                w_good_nxt = w_sync_lock ? r_good + 1'b1 : '0;
                if (w_sync_lock && (r_good == c_GOOD_LAST)) w_state_nxt = ST_LOCKED;
                else if (r_timer == c_TIMEOUT)              w_do_retry  = 1'b1;
            end
            ST_LOCKED: begin
                w_loss_nxt   = w_sync_lock ? '0 : r_loss + 1'b1;
                w_loss_event = !w_sync_done || (!w_sync_lock && (r_loss == c_LOSS_LAST));
            end
            ST_FAIL: begin
                w_state_nxt = ST_FAIL;
            end
        endcase

        if (w_do_retry) begin
            if (r_retry == c_RETRY_MAX) begin
                w_state_nxt = ST_FAIL;
            end else begin
                w_retry_nxt = r_retry + 1'b1;
                w_state_nxt = ST_RESET;
            end
        end

        if (w_loss_event) begin
            w_lol_nxt = 1'b1;
`ifdef PLL_CTRL_AUTO_RELOCK_EN
            w_state_nxt = ST_RESET;
            w_retry_nxt = '0;
`else
            w_state_nxt = ST_FAIL;
`endif
        end

        // Dropping enable overrides every other transition and its side effects.
        if (!enable) begin
            w_state_nxt = ST_IDLE;
            w_retry_nxt = r_retry;
            w_lol_nxt   = r_lol;
        end
    end

    always_ff @(posedge clk40 or posedge asynReset) begin
        if (asynReset) begin
            r_state <= ST_IDLE;
            r_timer <= '0;
            r_good  <= '0;
            r_loss  <= '0;
            r_retry <= '0;
            r_lol   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_retry <= w_retry_nxt;
            r_lol   <= w_lol_nxt;
            if (w_state_nxt != r_state) begin
                r_timer <= '0;
                r_good  <= '0;
                r_loss  <= '0;
            end else begin
                // Only bounded states advance the timer, so long stays cannot wrap it.
                if (w_dec.busy) r_timer <= r_timer + 1'b1;
                r_good <= w_good_nxt;
                r_loss <= w_loss_nxt;
            end
        end
    end

    always_ff @(posedge clk40 or posedge asynReset) begin
        if (asynReset) begin
            pllReset         <= 1'b1;
            startCalibration <= 1'b0;
            busy             <= 1'b0;
            locked           <= 1'b0;
            fail             <= 1'b0;
            lossOfLock       <= 1'b0;
            retryCount       <= '0;
        end else begin
            pllReset         <= w_dec.pll_reset;
            startCalibration <= w_dec.start_cal;
            busy             <= w_dec.busy;
            locked           <= w_dec.locked;
            fail             <= w_dec.fail;
            lossOfLock       <= r_lol;
            retryCount       <= r_retry;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pll_calibration_controller.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_pll_calibration_controller                                          |
// | Self-checking bench: event-time reference model, vector table, random. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module tb_pll_calibration_controller;

    localparam int RESET_HOLD  = 4;
    localparam int START_HOLD  = 2;
    localparam int CAL_TIMEOUT = 8191;
    localparam int LOCK_GOOD   = 16;
    localparam int LOSS_COUNT  = 4;
    localparam int SYNC_LAT    = 3;
    localparam int START_AT    = RESET_HOLD + 2;
    localparam int WAIT_AT     = START_AT + START_HOLD;
    localparam int TO_ROUND    = WAIT_AT + CAL_TIMEOUT + 1;
    localparam int NC          = 256;
    localparam int NEVER       = 1000000;
    localparam logic [7:0] IDLE_VEC = 8'b1000_0000;
`ifdef PLL_CTRL_AUTO_RELOCK_EN
    localparam bit RELOCK = 1'b1;
`else
    localparam bit RELOCK = 1'b0;
`endif

    logic       clk40 = 1'b0;
    logic       asynReset;
    logic       enable;
    logic       done_in;
    logic       lock_in;
    logic       pllReset;
    logic       startCalibration;
    logic       busy;
    logic       locked;
    logic       fail;
    logic       lossOfLock;
    logic [1:0] retryCount;
    logic [7:0] act;

    pll_calibration_controller dut (
        .clk40              (clk40),
        .asynReset          (asynReset),
        .enable             (enable),
        .pllCalibrationDone (done_in),
        .instantLock        (lock_in),
        .pllReset           (pllReset),
        .startCalibration   (startCalibration),
        .busy               (busy),
        .locked             (locked),
        .fail               (fail),
        .lossOfLock         (lossOfLock),
        .retryCount         (retryCount)
    );

    always #5 clk40 = ~clk40;

    assign act = {pllReset, startCalibration, busy, locked, fail, lossOfLock, retryCount};

    int n_tests = 0;
    int n_fail  = 0;

    // Input waveforms: element i is the value driven during cycle i (after edge i).
    logic dw [NC];
    logic lw [NC];

    typedef struct {
        int t_d;
        int t_l;
        int glitch;
        int drop_start;
        int drop_len;
        int exp_lk;
        int exp_loss;
    } vec_t;

    vec_t tbl [4];

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk40);
        #1;
    endtask

    // Expected outputs seen just after edge c, from the event edges of one run.
    function automatic logic [7:0] expect_seq(input int c, input int t_lk, input int t_loss);
        int   p;
        logic pr, sc, bz, lk, fl, ll;
        p  = c - 1;
        pr = (p < RESET_HOLD) || (p >= t_loss);
        sc = (p >= START_AT) && (p < WAIT_AT);
        bz = (p < t_lk) || (RELOCK && (p >= t_loss));
        lk = (p >= t_lk) && (p < t_loss);
        fl = !RELOCK && (p >= t_loss);
        ll = (p >= t_loss);
        return {pr, sc, bz, lk, fl, ll, 2'b00};
    endfunction

    function automatic void fill(input int t_d, input int t_l, input int g, input int ds, input int dl);
        for (int i = 0; i < NC; i++) begin
            dw[i] = (i >= t_d);
            lw[i] = (i >= t_l) && (i != g) && !((i >= ds) && (i < ds + dl));
        end
    endfunction

    // Edge at which calibration done is acted upon.
    function automatic int model_t_lc();
        for (int e = WAIT_AT + 1; e < NC + SYNC_LAT; e++)
            if (dw[e - SYNC_LAT]) return e;
        return NEVER;
    endfunction

    // First edge closing a run of LOCK_GOOD good samples entirely inside lock checking.
    function automatic int model_t_lk(input int t_lc);
        for (int e = t_lc + LOCK_GOOD; e < NC + SYNC_LAT; e++) begin
            bit ok;
            ok = 1'b1;
            for (int k = 0; k < LOCK_GOOD; k++)
                if (!lw[e - SYNC_LAT - k]) ok = 1'b0;
            if (ok) return e;
        end
        return NEVER;
    endfunction

    // First edge closing a run of LOSS_COUNT bad samples entirely inside the locked phase.
    function automatic int model_t_loss(input int t_lk);
        for (int e = t_lk + LOSS_COUNT; e < NC + SYNC_LAT; e++) begin
            bit bad;
            bad = 1'b1;
            for (int k = 0; k < LOSS_COUNT; k++)
                if (lw[e - SYNC_LAT - k]) bad = 1'b0;
            if (bad) return e;
        end
        return NEVER;
    endfunction

    task automatic run_scenario(input string tag, input int t_lk, input int t_loss, input int last_c);
        done_in = 1'b0;
        lock_in = 1'b0;
        enable  = 1'b1;
        for (int c = 0; c <= last_c; c++) begin
            step();
            if (c >= 1) check($sformatf("%s c%0d", tag, c), act, expect_seq(c, t_lk, t_loss));
            done_in = dw[c];
            lock_in = lw[c];
        end
        enable  = 1'b0;
        done_in = 1'b0;
        lock_in = 1'b0;
        repeat (6) step();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached after %0d tests", n_tests);
        $fatal(1, "bench time limit");
    end

    initial begin
        int t_d, t_l, g, ds, dl, t_lc, t_lk, t_loss, last_c;

        tbl[0] = '{0,  0,  -1, 27, 3, 25, NEVER};   // nominal, short dropout survives
        tbl[1] = '{20, 30, 39, 60, 4, 58, 66};      // glitch at 10th good sample, loss
        tbl[2] = '{5,  5,  -1, 30, 5, 25, 36};      // long dropout
        tbl[3] = '{12, 3,  -1, 40, 4, 31, 46};      // lock before done

        asynReset = 1'b1;
        enable    = 1'b0;
        done_in   = 1'b0;
        lock_in   = 1'b0;
        repeat (2) step();
        check("reset_state", act, IDLE_VEC);
        asynReset = 1'b0;
        repeat (3) step();
        check("idle_state", act, IDLE_VEC);

        for (int i = 0; i < 4; i++) begin
            fill(tbl[i].t_d, tbl[i].t_l, tbl[i].glitch, tbl[i].drop_start, tbl[i].drop_len);
            last_c = (tbl[i].exp_loss != NEVER) ? tbl[i].exp_loss + 4
                                                : tbl[i].drop_start + tbl[i].drop_len + 12;
            run_scenario($sformatf("vec%0d", i), tbl[i].exp_lk, tbl[i].exp_loss, last_c);
        end

        for (int it = 0; it < 24; it++) begin
            t_d = int'($urandom_range(0, 30));
            t_l = t_d + int'($urandom_range(0, 30));
            g   = ($urandom_range(0, 1) == 1) ? t_l + int'($urandom_range(0, 30)) : -1;
            fill(t_d, t_l, g, NC, 0);
            t_lc = model_t_lc();
            t_lk = model_t_lk(t_lc);
            ds   = t_lk + int'($urandom_range(2, 10));
            dl   = int'($urandom_range(1, 6));
            fill(t_d, t_l, g, ds, dl);
            t_loss = model_t_loss(t_lk);
            last_c = (t_loss != NEVER) ? t_loss + 4 : ds + dl + 12;
            run_scenario($sformatf("rnd%0d", it), t_lk, t_loss, last_c);
        end

        // enable dropped while waiting for calibration
        enable = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            step();
            done_in = 1'b0;
        end
        check("abort_wait_cal", act, expect_seq(20, NEVER, NEVER));
        enable = 1'b0;
        step();
        check("abort_en_hold", act, expect_seq(21, NEVER, NEVER));
        step();
        check("abort_en_idle", act, IDLE_VEC);
        repeat (6) step();

        // asynchronous reset pulse during lock checking
        fill(0, NC, -1, NC, 0);
        enable = 1'b1;
        for (int c = 0; c <= 15; c++) begin
            step();
            done_in = dw[c];
            lock_in = lw[c];
        end
        check("arst_lock_check", act, expect_seq(15, NEVER, NEVER));
        #2 asynReset = 1'b1;
        #1 check("arst_immediate", act, IDLE_VEC);
        step();
        asynReset = 1'b0;
        enable    = 1'b0;
        done_in   = 1'b0;
        lock_in   = 1'b0;
        step();
        check("arst_next_cycle", act, IDLE_VEC);
        repeat (6) step();

        // calibration never completes: four attempts, then FAIL
        enable = 1'b1;
        for (int c = 0; c <= TO_ROUND * 4 + 10; c++) begin
            step();
            for (int k = 0; k < 4; k++) begin
                if (c == TO_ROUND * k + 1)
                    check($sformatf("to_reset%0d", k), act, {6'b101000, 2'(k)});
                if (c == TO_ROUND * k + RESET_HOLD + 1)
                    check($sformatf("to_gap%0d", k), act, {6'b001000, 2'(k)});
                if (c == TO_ROUND * k + START_AT + 1)
                    check($sformatf("to_start%0d", k), act, {6'b011000, 2'(k)});
            end
            if (c == TO_ROUND * 4)
                check("to_last_wait", act, 8'b0010_0011);
            if (c == TO_ROUND * 4 + 1 || c == TO_ROUND * 4 + 10)
                check($sformatf("to_fail c%0d", c), act, 8'b1000_1011);
        end
        enable = 1'b0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pll_calibration_controller.md
# pll_calibration_controller

Sequencer that brings the readout PLL (simplePLL-style model) from reset to lock and keeps it there. It is the initiator side of the PLL control interface: it drives the PLL's active-high reset and calibration-start request, waits for calibration done, qualifies the PLL's instant-lock indication, and retries or flags failure. It sits in the clk40 slow-control domain between the configuration registers and the PLL.

## Interface
- RESET_HOLD, 4: cycles pllReset is held high in RESET.
- START_HOLD, 2: cycles startCalibration is held high (≥2 so the PLL's 2-stage edge detector sees it).
- CAL_TIMEOUT, 8191: max cycles in WAIT_CAL and in LOCK_CHECK (13-bit counter).
- LOCK_GOOD, 16: consecutive synced instantLock=1 samples required to declare lock.
- LOSS_COUNT, 4: consecutive instantLock=0 samples in LOCKED that declare loss of lock.
- MAX_RETRY, 3: retries before FAIL (2-bit retryCount).
- clk40  in  1  40 MHz reference clock; all logic on rising edge.
- asynReset  in  1  asynchronous, active-high reset.
- enable  in  1  level; 1 runs the sequence, 0 returns to IDLE.
- pllCalibrationDone  in  1  from PLL; 2-FF synchronized internally.
- instantLock  in  1  from PLL (clk1280-derived); 2-FF synchronized internally.
- pllReset  out  1  active-high reset to PLL.
- startCalibration  out  1  calibration request to PLL.
- busy  out  1  high in RESET, GAP, START, WAIT_CAL, LOCK_CHECK.
- locked  out  1  high only in LOCKED.
- fail  out  1  high only in FAIL.
- lossOfLock  out  1  sticky; set on a loss event, cleared on IDLE→RESET.
- retryCount  out  2  retries consumed in the current sequence.

## Operation
- States: IDLE, RESET, GAP, START, WAIT_CAL, LOCK_CHECK, LOCKED, FAIL. Shared 13-bit timer cleared on every state entry.
- IDLE: pllReset=1, other outputs 0. enable=1 → RESET, retryCount←0, lossOfLock←0.
- RESET: pllReset=1 for RESET_HOLD cycles → GAP.
- GAP: pllReset=0 for 2 cycles (PLL samples falling edge) → START.
- START: startCalibration=1 for START_HOLD cycles → WAIT_CAL.
- WAIT_CAL: syncDone=1 → LOCK_CHECK; else timer==CAL_TIMEOUT → RETRY. Same-cycle done and timeout: done wins.
- LOCK_CHECK: goodCnt (5-bit) increments on syncLock=1, clears on 0; syncLock=1 with goodCnt==LOCK_GOOD-1 → LOCKED; else timer==CAL_TIMEOUT → RETRY. Lock qualification wins over timeout.
- LOCKED: lossCnt increments on syncLock=0, clears on 1; lossCnt==LOSS_COUNT-1 with syncLock=0, or syncDone=0, → loss event: lossOfLock←1, then behaviour per Configuration.
- RETRY (transition action, not a state): retryCount==MAX_RETRY → FAIL; else retryCount+1, → RESET.
- FAIL: pllReset=1, fail=1; exits only via enable=0 → IDLE.
- enable=0 in any state → IDLE on next edge; highest priority.
- Counters saturate-free: each is cleared on state entry and cannot wrap within its bound.

## Timing
- Reset (asynReset=1): state=IDLE, pllReset=1, startCalibration=0, busy=0, locked=0, fail=0, lossOfLock=0, retryCount=0, synchronizers 0. Reset mid-operation aborts immediately, same values.
- Outputs registered (Moore), change one cycle after the state-changing edge.
- Input latency: 2 cycles synchronizer + 1 cycle decision.
- enable rise to startCalibration rise: RESET_HOLD+2+1 = 7 cycles at defaults.
- Minimum enable rise to locked: 7 + START_HOLD + done latency + LOCK_GOOD + 2.

## Configuration
- PLL_CTRL_AUTO_RELOCK_EN defined: loss event in LOCKED → RESET with retryCount←0 (lossOfLock stays 1).
- Not defined: loss event → FAIL; relock requires enable toggle.

## Structure
- Package pll_ctrl_pkg: state enum (3-bit), timer width 13, goodCnt width 5, default constants.
- Sub-module pll_ctrl_sync2: 2-FF synchronizer with async active-high reset, instantiated twice.

## Test plan
- Nominal: enable=1, PLL model with calibrationTime=100, lockTime=50 → startCalibration high 2 cycles at cycle 7, locked=1, retryCount=0, busy falls same cycle.
- Calibration timeout: pllCalibrationDone tied 0 → 4 RESET/START cycles, retryCount 0→3, fail=1 after 4×CAL_TIMEOUT-scale wait, pllReset=1.
- Lock glitch: instantLock drops once at sample 10 of LOCK_CHECK → goodCnt restarts, locked asserts 16 good samples after the glitch.
- Loss of lock: in LOCKED hold instantLock=0 4 cycles → lossOfLock=1; with macro re-enters RESET, relocks; without, fail=1.
- Short dropout: instantLock=0 for 3 cycles in LOCKED → remains locked, lossOfLock=0.
- Abort: enable=0 during WAIT_CAL, and asynReset pulse during LOCK_CHECK → IDLE, all outputs at reset values next cycle.
